// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding unit.
// Optional counters in the top are enabled by defining HAZARD_PERF_EN.
package pipe_pkg;

  localparam int REG_ADDR_W_DEF = 5;

  // Operand comes from the register file rather than a pipeline stage.
  localparam int FWD_RF = 0;

  typedef struct packed {
    logic                      valid;
    logic [REG_ADDR_W_DEF-1:0] rd;
    logic                      we;
    logic                      is_load;
  } entry_t;

endpackage

// File: rtl/hazard_match.sv
// Youngest-match search of one source register against all in-flight stages.
// Stage k lives at vector position k-1; stage 1 is the youngest.
module hazard_match
  import pipe_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int SEL_W      = $clog2(NUM_STAGES + 1)
) (
  input  logic [REG_ADDR_W-1:0]            src,
  input  logic [NUM_STAGES-1:0]            valid,
  input  logic [NUM_STAGES*REG_ADDR_W-1:0] rd,
  input  logic [NUM_STAGES-1:0]            we,
  input  logic [NUM_STAGES-1:0]            is_load,
  output logic [SEL_W-1:0]                 sel,
  output logic                             hit_load
);

  // Scan oldest to youngest so the youngest match is the last one written.
  always_comb begin
    sel      = SEL_W'(FWD_RF);
    hit_load = 1'b0;
    for (int k = NUM_STAGES; k >= 1; k--) begin
      if (valid[k-1] && we[k-1] && (src != '0) &&
          (rd[(k-1)*REG_ADDR_W +: REG_ADDR_W] == src)) begin
        sel      = SEL_W'(k);
        hit_load = is_load[k-1];
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_unit.sv
// Hazard and forwarding controller: tracks in-flight destinations, selects
// forwarding stages, stalls on load-use and bubbles on flush. HAZARD_PERF_EN adds counters.
module pipe_hazard_unit
  import pipe_pkg::*;
#(
  parameter int NUM_STAGES       = 3,
  parameter int REG_ADDR_W       = REG_ADDR_W_DEF,
  parameter int NUM_SRC          = 2,
  parameter int LOAD_READY_STAGE = 2,
  localparam int SEL_W           = $clog2(NUM_STAGES + 1)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          issue_valid,
  output logic                          issue_ready,
  input  logic [NUM_SRC*REG_ADDR_W-1:0] issue_src,
  input  logic [REG_ADDR_W-1:0]         issue_rd,
  input  logic                          issue_we,
  input  logic                          issue_is_load,
  input  logic                          flush,
  output logic [NUM_SRC*SEL_W-1:0]      fwd_sel,
  output logic                          retire_valid,
`ifdef HAZARD_PERF_EN
  output logic [REG_ADDR_W-1:0]         retire_rd,
  output logic [31:0]                   stall_count,
  output logic [31:0]                   flush_count
`else
  output logic [REG_ADDR_W-1:0]         retire_rd
`endif
);

  localparam logic [SEL_W-1:0] LOAD_READY = SEL_W'(LOAD_READY_STAGE);

  logic [NUM_STAGES-1:0]            valid_p;
  logic [NUM_STAGES*REG_ADDR_W-1:0] rd_p;
  logic [NUM_STAGES-1:0]            we_p;
  logic [NUM_STAGES-1:0]            load_p;

  logic [NUM_SRC*SEL_W-1:0] match_sel;
  logic [NUM_SRC-1:0]       match_load;
  logic [NUM_SRC-1:0]       src_stall;
  logic                     hazard;
  logic                     accept;

  for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
    hazard_match #(
      .NUM_STAGES(NUM_STAGES),
      .REG_ADDR_W(REG_ADDR_W),
      .SEL_W     (SEL_W)
    ) u_match (
      .src     (issue_src[s*REG_ADDR_W +: REG_ADDR_W]),
      .valid   (valid_p),
      .rd      (rd_p),
      .we      (we_p),
      .is_load (load_p),
      .sel     (match_sel[s*SEL_W +: SEL_W]),
      .hit_load(match_load[s])
    );

    // A load match is only ever reported for a nonzero stage index.
    assign src_stall[s] = match_load[s] && (match_sel[s*SEL_W +: SEL_W] < LOAD_READY);
  end

  assign hazard = |src_stall;

  // Outputs are forced to their idle values while reset is asserted, so
  // stale state from before the reset edge is never observed.
  always_comb begin
    issue_ready  = 1'b1;
    fwd_sel      = '0;
    retire_valid = 1'b0;
    retire_rd    = '0;
    if (!reset) begin
      issue_ready  = !(issue_valid && !flush && hazard);
      fwd_sel      = match_sel;
      retire_valid = valid_p[NUM_STAGES-1] && we_p[NUM_STAGES-1];
      if (retire_valid) begin
        retire_rd = rd_p[(NUM_STAGES-1)*REG_ADDR_W +: REG_ADDR_W];
      end
    end
  end

  assign accept = issue_valid && issue_ready && !flush && !reset;

  // Stage boundary: issue -> stage 1, then shift one stage per cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_p <= '0;
    end else begin
      valid_p <= {valid_p[NUM_STAGES-2:0], accept};
    end
  end

  always_ff @(posedge clk) begin
    rd_p   <= {rd_p[(NUM_STAGES-1)*REG_ADDR_W-1:0], issue_rd};
    we_p   <= {we_p[NUM_STAGES-2:0], issue_we};
    load_p <= {load_p[NUM_STAGES-2:0], issue_is_load};
  end

`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_count <= '0;
      flush_count <= '0;
    end else begin
      if (issue_valid && !issue_ready && (stall_count != '1)) begin
        stall_count <= stall_count + 32'd1;
      end
      if (issue_valid && flush && (flush_count != '1)) begin
        flush_count <= flush_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_unit.sv
// Directed bench for pipe_hazard_unit with default parameters
// (3 stages, 5-bit registers, 2 sources, loads forwardable from stage 2).
module tb_pipe_hazard_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic        issue_ready;
  logic [9:0]  issue_src;
  logic [4:0]  issue_rd;
  logic        issue_we;
  logic        issue_is_load;
  logic        flush;
  logic [3:0]  fwd_sel;
  logic        retire_valid;
  logic [4:0]  retire_rd;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_count;
  logic [31:0] flush_count;
`endif

  int checks = 0;
  int errors = 0;

  pipe_hazard_unit dut (
    .clk          (clk),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .issue_ready  (issue_ready),
    .issue_src    (issue_src),
    .issue_rd     (issue_rd),
    .issue_we     (issue_we),
    .issue_is_load(issue_is_load),
    .flush        (flush),
    .fwd_sel      (fwd_sel),
    .retire_valid (retire_valid),
`ifdef HAZARD_PERF_EN
    .retire_rd    (retire_rd),
    .stall_count  (stall_count),
    .flush_count  (flush_count)
`else
    .retire_rd    (retire_rd)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] s0, input logic [4:0] s1,
                       input logic [4:0] rd, input logic we, input logic ld, input logic fl);
    issue_valid   = v;
    issue_src     = {s1, s0};
    issue_rd      = rd;
    issue_we      = we;
    issue_is_load = ld;
    flush         = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    idle();

    // Reset held for two cycles
    for (int i = 0; i < 2; i++) begin
      chk("rst_ready", 32'(issue_ready), 32'd1);
      chk("rst_fwd", 32'(fwd_sel), 32'd0);
      chk("rst_retire", 32'(retire_valid), 32'd0);
      tick();
    end
    reset = 1'b0;
    idle();
    chk("post_rst_ready", 32'(issue_ready), 32'd1);
    chk("post_rst_retire_rd", 32'(retire_rd), 32'd0);
`ifdef HAZARD_PERF_EN
    chk("rst_stall_cnt", stall_count, 32'd0);
    chk("rst_flush_cnt", flush_count, 32'd0);
`endif

    // ALU back-to-back
    drive(1'b1, 5'd0, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0);
    chk("alu_a_ready", 32'(issue_ready), 32'd1);
    tick();
    drive(1'b1, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b0);
    chk("alu_b_fwd0", 32'(fwd_sel[1:0]), 32'd1);
    chk("alu_b_ready", 32'(issue_ready), 32'd1);
    tick();
    drive(1'b1, 5'd5, 5'd6, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("alu_c_fwd0", 32'(fwd_sel[1:0]), 32'd2);
    chk("alu_c_fwd1", 32'(fwd_sel[3:2]), 32'd1);
    chk("alu_c_retire_early", 32'(retire_valid), 32'd0);
    tick();
    idle();
    chk("alu_ret5_v", 32'(retire_valid), 32'd1);
    chk("alu_ret5_rd", 32'(retire_rd), 32'd5);
    tick();
    chk("alu_ret6_rd", 32'(retire_rd), 32'd6);
    tick();
    chk("alu_nowe_v", 32'(retire_valid), 32'd0);
    chk("alu_nowe_rd", 32'(retire_rd), 32'd0);
    tick();

    // Load-use stall
    drive(1'b1, 5'd0, 5'd0, 5'd7, 1'b1, 1'b1, 1'b0);
    tick();
    idle();
    issue_src = {5'd7, 5'd0};
    #1;
    chk("lu_novalid_ready", 32'(issue_ready), 32'd1);
    drive(1'b1, 5'd0, 5'd7, 5'd8, 1'b1, 1'b0, 1'b0);
    chk("lu_stall_ready", 32'(issue_ready), 32'd0);
    chk("lu_stall_fwd1", 32'(fwd_sel[3:2]), 32'd1);
    tick();
    chk("lu_go_ready", 32'(issue_ready), 32'd1);
    chk("lu_go_fwd1", 32'(fwd_sel[3:2]), 32'd2);
    tick();
    idle();
    chk("lu_ret7_rd", 32'(retire_rd), 32'd7);
    tick();
    chk("lu_bubble_v", 32'(retire_valid), 32'd0);
    tick();
    chk("lu_ret8_rd", 32'(retire_rd), 32'd8);
    tick();

    // x0 never forwards; youngest writer of a register wins
    drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b0, 5'd0, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("x0_fwd0", 32'(fwd_sel[1:0]), 32'd0);
    chk("yw_fwd1", 32'(fwd_sel[3:2]), 32'd1);
    chk("yw_ret9_old", 32'(retire_rd), 32'd9);
    tick();
    chk("yw_ret0_v", 32'(retire_valid), 32'd1);
    chk("yw_ret0_rd", 32'(retire_rd), 32'd0);
    tick();
    chk("yw_ret9_new", 32'(retire_rd), 32'd9);
    tick();

    // Flush overrides a load-use stall
    drive(1'b1, 5'd0, 5'd0, 5'd4, 1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b1, 5'd4, 5'd0, 5'd10, 1'b1, 1'b0, 1'b1);
    chk("fl_ready", 32'(issue_ready), 32'd1);
    tick();
    idle();
    issue_src = {5'd10, 5'd4};
    #1;
    chk("fl_no_fwd10", 32'(fwd_sel[3:2]), 32'd0);
    chk("fl_load_fwd", 32'(fwd_sel[1:0]), 32'd2);
    tick();
    chk("fl_ret4_rd", 32'(retire_rd), 32'd4);
    tick();
    chk("fl_dropped_v", 32'(retire_valid), 32'd0);
`ifdef HAZARD_PERF_EN
    chk("perf_stall_cnt", stall_count, 32'd1);
    chk("perf_flush_cnt", flush_count, 32'd1);
`endif
    tick();

    // Reset with three writers in flight
    drive(1'b1, 5'd0, 5'd0, 5'd11, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd0, 5'd12, 1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 5'd0, 5'd0, 5'd13, 1'b1, 1'b0, 1'b0);
    tick();
    reset = 1'b1;
    drive(1'b0, 5'd11, 5'd13, 5'd0, 1'b0, 1'b0, 1'b0);
    chk("mr_in_rst_retire", 32'(retire_valid), 32'd0);
    chk("mr_in_rst_fwd", 32'(fwd_sel), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("mr_retire", 32'(retire_valid), 32'd0);
      chk("mr_fwd", 32'(fwd_sel), 32'd0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
